reg_adder_checker: RTL and testbench
====================================

REG_ADDER_CHECKER -- requirements
Module: reg_adder_checker

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the operand and sum width.
REQ-002 The block SHALL have parameter CW, default 16, meaning the counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a check run.
REQ-006 The block SHALL have port stop, input, 1 bit: end a check run.
REQ-007 The block SHALL have ports a and b, input, N bits each: the stimulus operands driven to the DUT this cycle.
REQ-008 The block SHALL have ports c_in and select, input, 1 bit each: the stimulus carry-in and the invert-select driven to the DUT this cycle.
REQ-009 The block SHALL have ports dut_sum, input, N bits, and dut_c_out, input, 1 bit: the registered DUT outputs.
REQ-010 The block SHALL have ports busy and done, output, 1 bit each: run active; run finished.
REQ-011 The block SHALL have port pass, output, 1 bit: high iff done=1 and err_count=0.
REQ-012 The block SHALL have ports vec_count, err_count and first_err_idx, output, CW bits each: vectors compared; mismatches seen; index of the first mismatch.

Function
REQ-013 The expected value SHALL be exp_c_out = carry-out of (a + b + c_in) over N+1 bits, and exp_sum = ~a when select=1, else the low N bits of a+b+c_in; the carry SHALL be computed regardless of select.
REQ-014 The expectation SHALL be registered, so stimulus applied in cycle k is compared with dut_sum/dut_c_out in cycle k+1 (1-cycle alignment latency).
REQ-015 The FSM SHALL have the states IDLE, ARM, CHECK and DONE.
REQ-016 In IDLE, start=1 SHALL cause a transition to ARM, clearing vec_count, err_count and first_err_idx.
REQ-017 In ARM, the block SHALL capture the expectation and perform no compare; the next state SHALL be CHECK, or DONE if stop=1.
REQ-018 In CHECK, the block SHALL compare every cycle, increment vec_count (wrapping mod 2^CW), and capture a new expectation.
REQ-019 In CHECK, the compare SHALL also be performed in the cycle stop=1, after which the next state SHALL be DONE.
REQ-020 A mismatch SHALL be dut_sum != exp_sum OR dut_c_out != exp_c_out.
REQ-021 Each mismatch SHALL increment err_count, saturating at 2^CW-1 (no wrap).
REQ-022 On the first mismatch of a run, first_err_idx SHALL latch the pre-increment vec_count, and it SHALL hold thereafter.
REQ-023 In DONE, done=1 and all counters SHALL hold; start=1 SHALL cause a transition to ARM, clearing the counters.
REQ-024 start SHALL be ignored in ARM and CHECK.
REQ-025 When start and stop are both 1, stop SHALL take priority in ARM and CHECK, and start SHALL take priority in IDLE and DONE.
REQ-026 busy SHALL be 1 in ARM and CHECK, and 0 otherwise.
REQ-027 All outputs SHALL be registered or decoded only from registered state, with no combinational path from the inputs.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and busy, done, pass, vec_count, err_count, first_err_idx and the expectation registers SHALL all be 0.
REQ-029 Reset asserted mid-run (ARM, CHECK or DONE) SHALL abort the run immediately, without waiting for a clock edge.
REQ-030 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-031 Reset: rst_n=0 during CHECK with err_count=3 -> all outputs 0 before the next clk edge; IDLE after release.
REQ-032 Add match: start; then a=5, b=3, c_in=1, select=0; next cycle dut_sum=9, dut_c_out=0 with stop=1 -> done=1, pass=1, vec_count=1, err_count=0.
REQ-033 Select path: a=0x0000FFFF, b=1, c_in=0, select=1 -> expected dut_sum=0xFFFF0000, dut_c_out=0; feeding these -> no error.
REQ-034 Carry mismatch: a=0xFFFFFFFF, b=1, c_in=0, select=0 as the first vector, then dut_sum=0, dut_c_out=0 -> err_count=1, first_err_idx=0, pass=0.
REQ-035 Multi-error: 4 vectors with mismatches on vectors 2 and 3 -> err_count=2, first_err_idx=2, vec_count=4.
REQ-036 Simultaneous start and stop: both asserted in CHECK -> DONE with no re-arm; both asserted in DONE -> ARM with counters cleared.

Source files
------------

// File: rtl/reg_adder_checker.sv
// Purpose: self-checking monitor that compares a registered adder/inverter DUT against a reference expectation.
// Latency: the expectation is registered, so stimulus in cycle k is compared with the DUT outputs in cycle k+1.
// Backpressure: none; one compare per cycle while checking, and start/stop are sampled every cycle.
module reg_adder_checker #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          c_in,
    input  logic          select,
    input  logic [N-1:0]  dut_sum,
    input  logic          dut_c_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] vec_count,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  exp_sum_q, exp_sum_d;
    logic          exp_c_out_q, exp_c_out_d;
    logic [CW-1:0] vec_count_q, vec_count_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [CW-1:0] first_err_idx_q, first_err_idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic [N:0]    sum_full;
    logic [N-1:0]  exp_sum_w;
    logic          exp_c_out_w;
    logic          mismatch;

    // Reference model of the DUT for the current stimulus; carry is always from the add path.
    always_comb begin
        sum_full    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
        exp_sum_w   = select ? ~a : sum_full[N-1:0];
        exp_c_out_w = sum_full[N];
        mismatch    = (dut_sum != exp_sum_q) || (dut_c_out != exp_c_out_q);
    end

    // Run control, expectation capture and counter updates.
    always_comb begin
        state_d         = state_q;
        exp_sum_d       = exp_sum_q;
        exp_c_out_d     = exp_c_out_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_ARM;
                    vec_count_d     = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                end
            end
            S_ARM: begin
                // First vector is only captured here; its DUT result arrives next cycle.
                exp_sum_d   = exp_sum_w;
                exp_c_out_d = exp_c_out_w;
                state_d     = stop ? S_DONE : S_CHECK;
            end
            S_CHECK: begin
                vec_count_d = vec_count_q + CW'(1);
                if (mismatch) begin
                    if (err_count_q != {CW{1'b1}}) begin
                        err_count_d = err_count_q + CW'(1);
                    end
                    // err_count is cleared at run start and never returns to zero, so zero marks the first error.
                    if (err_count_q == '0) begin
                        first_err_idx_d = vec_count_q;
                    end
                end
                exp_sum_d   = exp_sum_w;
                exp_c_out_d = exp_c_out_w;
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d         = S_ARM;
                    vec_count_d     = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they can be registered alongside it.
    always_comb begin
        busy_d = (state_d == S_ARM) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_count_d == '0);
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            exp_sum_q       <= '0;
            exp_c_out_q     <= 1'b0;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            exp_sum_q       <= exp_sum_d;
            exp_c_out_q     <= exp_c_out_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_reg_adder_checker.sv
// Purpose: self-checking bench for reg_adder_checker; plays the DUT from a scoreboard of expected results.
// Latency: expected results are pushed when stimulus is driven and popped one cycle later as DUT outputs.
// Backpressure: none; inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_reg_adder_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        select;
    logic [31:0] dut_sum;
    logic        dut_c_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] vec_count;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb_q[$];

    // Per-run vector table: operands, carry-in, select, and corruption kind for the DUT result.
    logic [31:0] ta[8];
    logic [31:0] tb[8];
    logic        tc[8];
    logic        ts[8];
    logic [1:0]  tk[8];

    reg_adder_checker #(.N(32), .CW(16)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .a             (a),
        .b             (b),
        .c_in          (c_in),
        .select        (select),
        .dut_sum       (dut_sum),
        .dut_c_out     (dut_c_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sel);
        logic [32:0] t;
        t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (sel) t[31:0] = ~x;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_busy, input int e_done, input int e_pass,
                              input int e_vec, input int e_err, input int e_first);
        chk({tag, ".busy"},  {31'd0, busy},        e_busy);
        chk({tag, ".done"},  {31'd0, done},        e_done);
        chk({tag, ".pass"},  {31'd0, pass},        e_pass);
        chk({tag, ".vec"},   {16'd0, vec_count},   e_vec);
        chk({tag, ".err"},   {16'd0, err_count},   e_err);
        chk({tag, ".first"}, {16'd0, first_err_idx}, e_first);
    endtask

    // One cycle: play back the oldest expected result (optionally corrupted), drive stimulus, wait to the next falling edge.
    task automatic apply(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic is,
                         input logic strt, input logic stp, input logic push, input logic [1:0] corrupt);
        logic [32:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (corrupt == 2'd1) e[32] = ~e[32];
            if (corrupt == 2'd2) e[0]  = ~e[0];
            dut_sum   = e[31:0];
            dut_c_out = e[32];
        end
        a      = ia;
        b      = ib;
        c_in   = ic;
        select = is;
        start  = strt;
        stop   = stp;
        if (push) sb_q.push_back(model(ia, ib, ic, is));
        @(negedge clk);
    endtask

    // Start a run of n vectors from the table; start_mask re-asserts start on chosen vector cycles.
    task automatic run(input int n, input logic [7:0] start_mask, input logic do_stop);
        int last;
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        last = do_stop ? n : n - 1;
        for (int i = 0; i <= last; i++) begin
            apply(i < n ? ta[i] : 32'd0, i < n ? tb[i] : 32'd0,
                  i < n ? tc[i] : 1'b0, i < n ? ts[i] : 1'b0,
                  start_mask[i], do_stop && (i == n), i < n,
                  i > 0 ? tk[i-1] : 2'd0);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        a = '0; b = '0; c_in = 1'b0; select = 1'b0; dut_sum = '0; dut_c_out = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check_outs("idle_wait", 0, 0, 0, 0, 0, 0);

        // Add match: 5 + 3 + 1 = 9.
        ta[0] = 32'd5; tb[0] = 32'd3; tc[0] = 1'b1; ts[0] = 1'b0; tk[0] = 2'd0;
        run(1, 8'h00, 1'b1);
        chk("add.dut_sum_fed", dut_sum, 32'd9);
        check_outs("add", 0, 1, 1, 1, 0, 0);

        // Select path: ~0x0000FFFF with carry from 0xFFFF+1.
        ta[0] = 32'h0000FFFF; tb[0] = 32'd1; tc[0] = 1'b0; ts[0] = 1'b1; tk[0] = 2'd0;
        run(1, 8'h00, 1'b1);
        chk("sel.dut_sum_fed", dut_sum, 32'hFFFF0000);
        chk("sel.dut_c_fed", {31'd0, dut_c_out}, 32'd0);
        check_outs("sel", 0, 1, 1, 1, 0, 0);

        // Carry mismatch on the first vector: DUT reports 0/0 where 0 with carry 1 is due.
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'd1; tc[0] = 1'b0; ts[0] = 1'b0; tk[0] = 2'd1;
        run(1, 8'h00, 1'b1);
        chk("carry.dut_sum_fed", dut_sum, 32'd0);
        chk("carry.dut_c_fed", {31'd0, dut_c_out}, 32'd0);
        check_outs("carry", 0, 1, 0, 1, 1, 0);

        // Four random vectors, errors on 2 and 3; start during CHECK must be ignored.
        for (int i = 0; i < 4; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; tc[i] = 1'($urandom_range(0, 1));
            ts[i] = 1'($urandom_range(0, 1)); tk[i] = 2'd0;
        end
        tk[2] = 2'd2; tk[3] = 2'd1;
        run(4, 8'h08, 1'b1);
        check_outs("multi", 0, 1, 0, 4, 2, 2);

        // Mid-run reset with three errors accumulated while still checking.
        for (int i = 0; i < 4; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; tc[i] = 1'b0; ts[i] = 1'b0; tk[i] = 2'd2;
        end
        run(4, 8'h00, 1'b0);
        check_outs("pre_rst", 1, 0, 0, 3, 3, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 0, 0, 0, 0, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check_outs("post_rst", 0, 0, 0, 0, 0, 0);

        // Start and stop together: stop wins in CHECK, start wins in DONE, then stop in ARM.
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        apply(32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        check_outs("both_check", 0, 1, 0, 1, 1, 0);
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        check_outs("both_done", 1, 0, 0, 0, 0, 0);
        apply(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        check_outs("stop_arm", 0, 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
